// File: rtl/axis_mem2m.sv
//==============================================================================
// Module   : axis_mem2m
// Purpose  : Streams one FFT frame from memory 0 port A onto an AXI-Stream
//            master. Optional macro MEM2M_BITREV_EN selects bit-reversed
//            read addressing (FFT output reordering).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 44
`endif

module axis_mem2m #(
    parameter int FFT_SIZE   = 4096,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  axis_tx,
    output logic                  axis_mem2m_clken,
    output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
    input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  done
);

    localparam int              CNT_W    = $clog2(FFT_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             axis_tx_q;
    logic             tvalid_q;
    logic             tlast_q;
    logic             done_q;
    logic             clken;
    logic [CNT_W-1:0] addr_d;

    // A read is only issued when the output register is free or being drained,
    // so a stalled beat keeps the RAM output (and thus tdata) frozen.
    assign clken = axis_tx_q & (~tvalid_q | m_axis_tready);

`ifdef MEM2M_BITREV_EN
    always_comb begin
        addr_d = '0;
        for (int i = 0; i < CNT_W; i++) begin
            addr_d[i] = cnt_q[CNT_W-1-i];
        end
    end
`else
    always_comb begin
        addr_d = cnt_q;
    end
`endif

    assign axis_mem2m_raddr = ADDR_WIDTH'(addr_d);
    assign axis_mem2m_clken = clken;
    assign axis_tx          = axis_tx_q;
    assign m_axis_tdata     = axis_mem2m_rdata;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign done             = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            axis_tx_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        axis_tx_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (clken) begin
                        cnt_q    <= cnt_q + 1'b1;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (cnt_q == LAST_CNT);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DRAIN;
                        end
                    end else if (tvalid_q && m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // cnt is frozen here; any clken re-reads a harmless address
                    if (tvalid_q && m_axis_tready) begin
                        state_q   <= IDLE;
                        tvalid_q  <= 1'b0;
                        tlast_q   <= 1'b0;
                        done_q    <= 1'b1;
                        axis_tx_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_mem2m.sv
//==============================================================================
// Module   : tb_axis_mem2m
// Purpose  : Directed self-checking bench for axis_mem2m with FFT_SIZE=16.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_mem2m;

    localparam int N  = 16;
    localparam int AW = 12;
    localparam int DW = 44;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          tready;
    logic          axis_tx;
    logic          clken;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int nwords;
    int done_cyc;
    int first_cyc;
    int rel_cyc;

    axis_mem2m #(
        .FFT_SIZE  (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .axis_tx         (axis_tx),
        .axis_mem2m_clken(clken),
        .axis_mem2m_raddr(raddr),
        .axis_mem2m_rdata(rdata),
        .m_axis_tdata    (tdata),
        .m_axis_tvalid   (tvalid),
        .m_axis_tready   (tready),
        .m_axis_tlast    (tlast),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, output held while clken is low
    always @(posedge clk) begin
        if (clken) rdata <= mem[raddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int k);
        logic [3:0] v;
        v = k[3:0];
`ifdef MEM2M_BITREV_EN
        return DW'({v[0], v[1], v[2], v[3]}) | DW'(k & ~15);
`else
        return DW'(v) | DW'(k & ~15);
`endif
    endfunction

    // mode 0: tready=1; 1: backpressure; 2: stall on tlast; 3: extra start mid-frame
    task automatic stream(input int mode);
        int   hold;
        int   stall5;
        logic rdy;
        hold      = 0;
        stall5    = 0;
        nwords    = 0;
        done_cyc  = -1;
        first_cyc = -1;
        rel_cyc   = -1;
        for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
            start = (mode == 3 && cyc == 8);
            rdy   = 1'b1;
            if (mode == 1 && nwords == 5 && tvalid && stall5 < 3) begin
                rdy = 1'b0;
                stall5++;
            end else if (mode == 1 && nwords > 5 && (cyc % 2) == 1) begin
                rdy = 1'b0;
            end
            if (mode == 2 && tvalid && tlast && hold < 3) begin
                rdy = 1'b0;
                hold++;
                if (hold == 3) rel_cyc = cyc + 1;
            end
            tready = rdy;
            #1;
            if (done) begin
                done_cyc = cyc;
                check("axis_tx_low_at_done", {63'd0, axis_tx}, 64'd0);
            end
            if (tvalid && first_cyc < 0) first_cyc = cyc;
            if (tvalid) begin
                check("tdata", 64'(tdata), 64'(exp_word(nwords)));
                check("tlast", {63'd0, tlast}, {63'd0, nwords == N - 1});
                if (!rdy) check("clken_low_in_stall", {63'd0, clken}, 64'd0);
                if (mode == 2 && !rdy) begin
                    check("drain_axis_tx", {63'd0, axis_tx}, 64'd1);
                    check("drain_no_done", {63'd0, done}, 64'd0);
                end
                if (rdy) nwords++;
            end
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        tready = 1'b1;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i < N) ? DW'(i) : '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid",  {63'd0, tvalid},  64'd0);
        check("rst_tlast",   {63'd0, tlast},   64'd0);
        check("rst_axis_tx", {63'd0, axis_tx}, 64'd0);
        check("rst_done",    {63'd0, done},    64'd0);
        check("rst_clken",   {63'd0, clken},   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate frame
        kick();
        stream(0);
        check("a_words",     64'(nwords),    64'd16);
        check("a_first_cyc", 64'(first_cyc), 64'd2);
        check("a_done_cyc",  64'(done_cyc),  64'd18);
        check("a_done_once", {63'd0, done},  64'd0);
        check("a_idle_tx",   {63'd0, axis_tx}, 64'd0);

        // Backpressure
        kick();
        stream(1);
        check("b_words",     64'(nwords), 64'd16);
        check("b_done_seen", {63'd0, done_cyc > 0}, 64'd1);

        // Stall on the tlast word
        kick();
        stream(2);
        check("c_words",    64'(nwords),   64'd16);
        check("c_done_cyc", 64'(done_cyc), 64'(rel_cyc + 1));

        // Extra start mid-frame
        kick();
        stream(3);
        check("d_words",    64'(nwords),   64'd16);
        check("d_done_cyc", 64'(done_cyc), 64'd18);
        @(posedge clk);
        #1;
        check("d_stays_idle", {63'd0, axis_tx}, 64'd0);

        // Reset mid-frame at word 7
        kick();
        nwords = 0;
        for (int c = 0; c < 40 && nwords < 7; c++) begin
            if (tvalid) nwords++;
            @(posedge clk);
            #1;
        end
        check("e_at_word7", 64'(tdata), 64'(exp_word(7)));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("e_rst_tvalid",  {63'd0, tvalid},  64'd0);
        check("e_rst_axis_tx", {63'd0, axis_tx}, 64'd0);
        check("e_rst_done",    {63'd0, done},    64'd0);
        check("e_rst_clken",   {63'd0, clken},   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        kick();
        stream(0);
        check("f_words",     64'(nwords),    64'd16);
        check("f_first_cyc", 64'(first_cyc), 64'd2);
        check("f_done_cyc",  64'(done_cyc),  64'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_mem2m.md
AXIS_MEM2M -- requirements
Module: axis_mem2m

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 4096, meaning the number of words streamed per frame (power of two, at least 4).
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (12), meaning the width of the memory read address.
REQ-003 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (44), meaning the width of the memory word and of the stream word.
REQ-004 SHALL have ports, in this order:
 - clk  in  1  the single clock; all logic on its rising edge.
 - rst_n  in  1  reset; synchronous, active-low.
 - start  in  1  one-cycle pulse that begins a frame transfer.
 - axis_tx  out  1  high while the block owns memory 0 port A.
 - axis_mem2m_clken  out  1  memory 0 port A enable (read clock-enable).
 - axis_mem2m_raddr  out  ADDR_WIDTH  memory 0 port A read address.
 - axis_mem2m_rdata  in  DATA_WIDTH  memory 0 port A read data; 1-cycle latency after an enabled read; held while the enable is low.
 - m_axis_tdata  out  DATA_WIDTH  stream data; equals axis_mem2m_rdata.
 - m_axis_tvalid  out  1  stream valid.
 - m_axis_tready  in  1  stream ready.
 - m_axis_tlast  out  1  marks the final word of a frame.
 - done  out  1  one-cycle pulse when the last word has been accepted.

Function
REQ-005 SHALL implement an FSM with the states IDLE, RUN and DRAIN.
REQ-006 SHALL, in IDLE, move to RUN on start=1, clear the word counter cnt to 0, and set axis_tx=1 from the next cycle.
REQ-007 SHALL hold axis_tx=1 in RUN and in DRAIN, and axis_tx=0 in IDLE.
REQ-008 SHALL drive axis_mem2m_clken = axis_tx AND (NOT m_axis_tvalid OR m_axis_tready), combinationally.
REQ-009 SHALL drive axis_mem2m_raddr from cnt combinationally (see REQ-019).
REQ-010 SHALL, on each RUN cycle with clken=1, perform all of the following:
 - increment cnt;
 - set m_axis_tvalid<=1;
 - set m_axis_tlast<=(cnt==FFT_SIZE-1);
 - if cnt==FFT_SIZE-1, move to DRAIN.
REQ-011 SHALL, when m_axis_tvalid=1 and m_axis_tready=1 and no read is issued in that cycle, clear m_axis_tvalid<=0 and m_axis_tlast<=0.
REQ-012 SHALL, in DRAIN, issue no new reads: cnt is held, and any clken pulse re-reads the same address harmlessly.
REQ-013 SHALL, in DRAIN, on the handshake of the tlast word, do all of the following:
 - go to IDLE;
 - clear tvalid and tlast;
 - pulse done=1 for one cycle;
 - drop axis_tx in the next cycle.
REQ-014 SHALL keep m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0, relying on clken=0 to hold the RAM output.
REQ-015 SHALL sustain one word per cycle with tready held high, giving the first tvalid 2 cycles after start and a frame time of FFT_SIZE+2 cycles from start to done.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL let cnt wrap naturally and never address beyond FFT_SIZE-1.

Reset
REQ-018 SHALL, on rst_n=0 at a clock edge, force all of the following, including in the middle of a frame, with no partial-frame recovery:
 - state=IDLE;
 - cnt=0;
 - axis_tx=0, so clken=0;
 - m_axis_tvalid=0;
 - m_axis_tlast=0;
 - done=0.

Configuration
REQ-019 SHALL support the macro MEM2M_BITREV_EN:
 - when defined, axis_mem2m_raddr = bit-reverse of the low log2(FFT_SIZE) bits of cnt (FFT output reordering);
 - when undefined, axis_mem2m_raddr = cnt (natural order).
 - Handshake, tlast and timing SHALL be identical in both builds.

Verification
REQ-020 SHALL be checked with a bench using FFT_SIZE=16, covering these scenarios:
 - Natural order, tready=1, RAM word i preloaded with value i: start pulse → tdata 0..15 on consecutive cycles, tlast only with 15, done 18 cycles after start.
 - MEM2M_BITREV_EN defined, same preload → tdata sequence 0,8,4,12,2,10,...,15; tlast with 15.
 - Backpressure (tready low for 3 cycles at word 5, and low every other cycle afterwards) → no word lost or duplicated; tdata stable while stalled; clken=0 whenever tvalid=1 and tready=0.
 - tready=0 on the last word → stays in DRAIN with axis_tx=1; releasing tready gives done one cycle later.
 - Extra start pulse mid-frame → ignored, exactly 16 words.
 - rst_n low at word 7 → next cycle tvalid=0, axis_tx=0, done=0; a fresh start then streams from word 0.
